// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS instruction-fetch stage owning the PC, the imem handshake and the IF/ID register
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             if_id_valid,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc4,
  output logic [31:0]      if_id_instr,
  output logic [CNT_W-1:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d, pending_pc_q, pending_pc_d;
  logic             if_id_valid_q, if_id_valid_d;
  logic [31:0]      if_id_pc_q, if_id_pc_d, if_id_pc4_q, if_id_pc4_d, if_id_instr_q, if_id_instr_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic [31:0]      target, pc_inc;
  assign target      = {redirect_pc[31:2], 2'b00};
  assign pc_inc      = pc_q + 32'd4;
  assign imem_req    = state_q != IDLE;
  assign imem_addr   = pc_q;
  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_instr = if_id_instr_q;
  assign fetch_count = fetch_count_q;
  // next state: redirect beats stall, stall beats a returned word; a redirect mid-request drains the old word first
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_pc_d  = pending_pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_instr_d = if_id_instr_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (redirect && imem_ready) begin
          pc_d          = target;
          if_id_valid_d = 1'b0;
        end else if (redirect) begin
          pending_pc_d  = target;
          if_id_valid_d = 1'b0;
          state_d       = DRAIN;
        end else if (!stall) begin
          if_id_valid_d = imem_ready;
          if (imem_ready) begin
            if_id_instr_d = imem_rdata;
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc_inc;
            pc_d          = pc_inc;
            fetch_count_d = fetch_count_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if_id_valid_d = 1'b0;
        pending_pc_d  = redirect ? target : pending_pc_q;
        if (imem_ready) begin
          pc_d    = redirect ? target : pending_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and pipeline register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pending_pc_q  <= '0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_pc4_q   <= '0;
      if_id_instr_q <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_pc_q  <= pending_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed and random fetch traffic checked against a cycle-level reference model
module tb_if_fetch_stage;
  logic clk = 0, rst = 1;
  logic imem_req, imem_ready = 0, stall = 0, redirect = 0, if_id_valid;
  logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, if_id_pc, if_id_pc4, if_id_instr, fetch_count;
  logic w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_pc4, w_instr, w_cnt;
  int n_vec = 0, n_err = 0;
  logic [31:0] m_pc, m_pend, m_ipc, m_ipc4, m_instr, m_cnt;
  logic m_v;
  int m_mode;
  always #5 clk = ~clk;
  if_fetch_stage dut (.clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr), .fetch_count(fetch_count));
  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (.clk(clk), .rst(rst), .imem_req(w_req),
    .imem_addr(w_addr), .imem_ready(1'b1), .imem_rdata(32'h1234_5678), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(32'h0), .if_id_valid(w_valid), .if_id_pc(w_pc),
    .if_id_pc4(w_pc4), .if_id_instr(w_instr), .fetch_count(w_cnt));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_pc = 0; m_pend = 0; m_ipc = 0; m_ipc4 = 0; m_instr = 0; m_cnt = 0; m_v = 0; m_mode = 0;
  endtask
  task automatic check_all();
    chk("req", 32'(imem_req), 32'(m_mode != 0));
    chk("addr", imem_addr, m_pc);
    chk("valid", 32'(if_id_valid), 32'(m_v));
    chk("if_pc", if_id_pc, m_ipc);
    chk("if_pc4", if_id_pc4, m_ipc4);
    chk("instr", if_id_instr, m_instr);
    chk("count", fetch_count, m_cnt);
  endtask
  task automatic cyc(input logic s, input logic r, input logic [31:0] rpc, input logic rdy, input logic [31:0] data);
    logic [31:0] t;
    stall = s; redirect = r; redirect_pc = rpc; imem_ready = rdy; imem_rdata = data;
    @(posedge clk);
    t = rpc & 32'hFFFF_FFFC;
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (r) begin
        m_v = 0;
        if (rdy) m_pc = t; else begin m_pend = t; m_mode = 2; end
      end else if (!s) begin
        m_v = rdy;
        if (rdy) begin m_instr = data; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_pc = m_pc + 4; m_cnt++; end
      end
    end else begin
      m_v = 0;
      if (r) m_pend = t;
      if (rdy) begin m_pc = m_pend; m_mode = 1; end
    end
    #1;
    check_all();
  endtask
  task automatic run(input logic s, input logic r, input logic [31:0] rpc, input logic rdy);
    cyc(s, r, rpc, rdy, 32'h0100_0020 + m_pc);
  endtask
  initial begin
    model_reset();
    #12 rst = 0;
    check_all();
    run(0, 0, 0, 1);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    run(0, 0, 0, 1);
    chk("wrap_addr1", w_addr, 32'h0);
    chk("wrap_pc4", w_pc4, 32'h0);
    chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
    run(0, 0, 0, 1);
    chk("pc4_first", if_id_pc4, 32'h8);
    repeat (3) run(1, 0, 0, 1);
    chk("stall_addr", imem_addr, 32'h8);
    chk("stall_pc", if_id_pc, 32'h4);
    run(0, 0, 0, 1);
    chk("after_stall", if_id_pc, 32'h8);
    repeat (2) run(0, 0, 0, 0);
    chk("wait_addr", imem_addr, 32'hC);
    run(0, 0, 0, 1);
    chk("count4", fetch_count, 32'd4);
    chk("c_instr", if_id_instr, 32'h0100_002C);
    run(0, 1, 32'h80, 0);
    run(0, 1, 32'h90, 0);
    run(1, 0, 0, 0);
    chk("drain_addr", imem_addr, 32'h10);
    run(0, 0, 0, 1);
    chk("redir_addr", imem_addr, 32'h90);
    run(0, 1, 32'h43, 1);
    chk("redir43", imem_addr, 32'h40);
    chk("redir_flush", 32'(if_id_valid), 32'h0);
    run(0, 0, 0, 1);
    chk("load40", if_id_pc, 32'h40);
    run(0, 1, 32'h200, 0);
    #2 rst = 1;
    #1 model_reset();
    check_all();
    #2 rst = 0;
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom,
          $urandom_range(0, 9) < 7, $urandom);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS CPU.
- Owns the PC and issues word requests to instruction memory under a req/ready handshake.
- Fills the IF/ID pipeline register consumed by decode.
- Applies decode/execute stall and redirect commands (taken BEQ, J).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
CNT_W, 32, width of the fetched-instruction counter.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  byte address of the requested word (little-endian memory, word aligned).
imem_ready  input  1  memory returns imem_rdata this cycle for the current request.
imem_rdata  input  32  fetched instruction word.
stall  input  1  hazard unit: hold the IF/ID register and PC.
redirect  input  1  taken branch or jump: refetch from redirect_pc.
redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 00).
if_id_valid  output  1  IF/ID holds a real instruction.
if_id_pc  output  32  address of the instruction in IF/ID.
if_id_pc4  output  32  if_id_pc + 4.
if_id_instr  output  32  instruction word in IF/ID.
fetch_count  output  CNT_W  number of instructions loaded into IF/ID.

Behaviour:
- Reset (async, any time, including mid-request):
  - pc=RESET_PC, state=IDLE, pending_pc=0.
  - if_id_valid=0, if_id_pc=0, if_id_pc4=0, if_id_instr=0, fetch_count=0.
  - imem_req=0.
- imem_addr always equals pc in IDLE and FETCH. In DRAIN it equals pc, which is the in-flight request address.
- Handshake rule: while imem_req=1 and imem_ready=0, imem_addr stays stable. A request is never withdrawn before ready.
- IDLE: imem_req=0. Next edge goes to FETCH, so the first request is 1 cycle after rst deasserts.
- FETCH (imem_req=1). Edge priority, highest first:
  - redirect=1, imem_ready=1: pc<=redirect_pc&~3, if_id_valid<=0. Returned data is discarded. Stay in FETCH.
  - redirect=1, imem_ready=0: pending_pc<=redirect_pc&~3, if_id_valid<=0, go to DRAIN. pc is held.
  - stall=1: pc and the IF/ID register are held. A word returned with ready=1 is discarded and the same pc is refetched next cycle.
  - imem_ready=1:
    - if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_pc4<=pc+4, if_id_valid<=1.
    - pc<=pc+4.
    - fetch_count<=fetch_count+1.
  - imem_ready=0: if_id_valid<=0 (bubble). Other IF/ID fields are held.
- DRAIN (imem_req=1, old address):
  - if_id_valid held at 0. stall is ignored.
  - A new redirect overwrites pending_pc.
  - On imem_ready=1: data is discarded, pc<=pending_pc (or the new redirect target if redirect=1 in the same cycle), go to FETCH.
- Redirect overrides stall in all states. A redirect flushes IF/ID on the same edge.
- Arithmetic:
  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  - fetch_count wraps modulo 2^CNT_W.
  - if_id_pc4 is computed with the same wrap.
- Bubbles and discarded words never increment fetch_count.
- Latency: an instruction returned with ready=1 in FETCH is visible on the IF/ID outputs 1 cycle later.

Test Plan:
- Reset then run, imem_ready=1, memory returns 32'h0100_0020+addr:
  - Required: IF/ID pcs 0,4,8,C on consecutive cycles.
  - Required: if_id_pc4 equals if_id_pc+4.
  - Required: fetch_count reaches 4 after 4 valid loads.
- stall=1 for 3 cycles at pc=8:
  - Required: IF/ID holds pc=4 and its instruction.
  - Required: imem_addr stays 8 and fetch_count is unchanged.
  - Required: after release, pc=8 enters IF/ID.
- imem_ready=0 for 2 cycles at pc=C:
  - Required: imem_addr held at C and if_id_valid=0 for 2 cycles.
  - Required: the C instruction loads on ready.
- redirect=1, redirect_pc=32'h0000_0043, ready=1:
  - Required: next imem_addr=32'h40 and if_id_valid=0 for 1 cycle.
  - Required: the 0x40 instruction is loaded next.
- Redirect during wait (ready=0 at pc=10, redirect to 0x80, then second redirect to 0x90 before ready):
  - Required: imem_addr stays 10 until ready.
  - Required: the word is discarded and the next fetch is at 0x90.
- Async rst pulse mid-DRAIN plus pc wrap test:
  - rst pulse, no clock edge: outputs clear immediately.
  - RESET_PC=32'hFFFF_FFFC: second fetch address is 0 and if_id_pc4=0.
